// File: rtl/vga_timing_if.sv
// vga_timing_if -- connection bundle between the raster timing generator and
// the blocks around it (VGA register block and pixel fetch path).
//   vga_en       enable from the register block
//   pix_tick     1-clk strobe per pixel period
//   hcount       current pixel column
//   vcount       current line
//   hblank       column is outside the visible area
//   vblank       line is outside the visible area
//   de           display enable (visible pixel while running)
//   hsync/vsync  sync pulses
//   line_start   1-clk strobe when a line begins
//   frame_start  1-clk strobe when a frame begins
// master: the timing generator. slave: a consumer that also supplies vga_en.
interface vga_timing_if;
  logic        vga_en;
  logic        pix_tick;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hblank;
  logic        vblank;
  logic        de;
  logic        hsync;
  logic        vsync;
  logic        line_start;
  logic        frame_start;

  modport master (
    input  vga_en,
    output pix_tick, hcount, vcount, hblank, vblank, de,
           hsync, vsync, line_start, frame_start
  );

  modport slave (
    output vga_en,
    input  pix_tick, hcount, vcount, hblank, vblank, de,
           hsync, vsync, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen -- raster timing generator.
// Divides clk by CLK_DIV into a pixel tick and walks an H_TOTAL x V_TOTAL
// raster. Starting and stopping happen only on frame boundaries: a drop of
// vga_en lets the current frame finish before the generator goes idle.
// Ports:
//   clk   clock
//   rst   synchronous reset, active-high
//   vif   vga_timing_if.master: vga_en in; pix_tick, hcount, vcount, hblank,
//         vblank, de, hsync, vsync, line_start, frame_start out (all registered)
module vga_timing_gen #(
  parameter int   CLK_DIV  = 4,
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  vga_timing_if.master vif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [10:0]   H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0]   V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0]   H_ACT      = 11'(H_ACTIVE);
  localparam logic [10:0]   V_ACT      = 11'(V_ACTIVE);
  localparam logic [10:0]   HS_BEGIN   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0]   HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0]   VS_BEGIN   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0]   VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state_reg, state_next;
  logic [PW-1:0] presc_reg, presc_next;
  // Set by the first pixel tick after leaving IDLE; until then the raster
  // outputs keep their idle values even though the prescaler is counting.
  logic          started_reg, started_next;
  logic [10:0]   hcount_reg, hcount_next;
  logic [10:0]   vcount_reg, vcount_next;
  logic          pix_tick_reg, pix_tick_next;
  logic          line_start_reg, line_start_next;
  logic          frame_start_reg, frame_start_next;
  logic          hblank_reg, hblank_next;
  logic          vblank_reg, vblank_next;
  logic          de_reg, de_next;
  logic          hsync_reg, hsync_next;
  logic          vsync_reg, vsync_next;

  logic tick, h_last, v_last, stop;

  always_comb begin
    state_next       = state_reg;
    presc_next       = presc_reg;
    started_next     = started_reg;
    hcount_next      = hcount_reg;
    vcount_next      = vcount_reg;
    pix_tick_next    = 1'b0;
    line_start_next  = 1'b0;
    frame_start_next = 1'b0;

    tick   = (state_reg != IDLE) && (presc_reg == PRESC_LAST);
    h_last = (hcount_reg == H_LAST);
    v_last = (vcount_reg == V_LAST);
    // Draining and still disabled on the tick that would wrap the frame.
    stop   = started_reg && (state_reg == DRAIN) && !vif.vga_en && h_last && v_last;

    unique case (state_reg)
      IDLE:    if (vif.vga_en)  state_next = RUN;
      RUN:     if (!vif.vga_en) state_next = DRAIN;
      DRAIN:   if (vif.vga_en)  state_next = RUN;
      default: state_next = IDLE;
    endcase

    if (state_reg == IDLE || tick) presc_next = '0;
    else                           presc_next = presc_reg + PW'(1);

    if (tick) begin
      if (stop) begin
        // The wrap tick is swallowed: go straight to idle values.
        state_next   = IDLE;
        started_next = 1'b0;
        hcount_next  = '0;
        vcount_next  = '0;
      end else if (!started_reg) begin
        // First pixel: counters already sit at (0,0), so they do not advance.
        started_next     = 1'b1;
        pix_tick_next    = 1'b1;
        line_start_next  = 1'b1;
        frame_start_next = 1'b1;
      end else begin
        pix_tick_next = 1'b1;
        if (h_last) begin
          hcount_next     = '0;
          line_start_next = 1'b1;
          if (v_last) begin
            vcount_next      = '0;
            frame_start_next = 1'b1;
          end else begin
            vcount_next = vcount_reg + 11'd1;
          end
        end else begin
          hcount_next = hcount_reg + 11'd1;
        end
      end
    end

    // Decoded from the next counter values so they line up with hcount/vcount.
    hblank_next = !started_next || (hcount_next >= H_ACT);
    vblank_next = !started_next || (vcount_next >= V_ACT);
    de_next     = !hblank_next && !vblank_next;
    hsync_next  = (started_next && hcount_next >= HS_BEGIN && hcount_next < HS_END)
                  ? SYNC_POL : ~SYNC_POL;
    vsync_next  = (started_next && vcount_next >= VS_BEGIN && vcount_next < VS_END)
                  ? SYNC_POL : ~SYNC_POL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      presc_reg       <= '0;
      started_reg     <= 1'b0;
      hcount_reg      <= '0;
      vcount_reg      <= '0;
      pix_tick_reg    <= 1'b0;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
      hblank_reg      <= 1'b1;
      vblank_reg      <= 1'b1;
      de_reg          <= 1'b0;
      hsync_reg       <= ~SYNC_POL;
      vsync_reg       <= ~SYNC_POL;
    end else begin
      state_reg       <= state_next;
      presc_reg       <= presc_next;
      started_reg     <= started_next;
      hcount_reg      <= hcount_next;
      vcount_reg      <= vcount_next;
      pix_tick_reg    <= pix_tick_next;
      line_start_reg  <= line_start_next;
      frame_start_reg <= frame_start_next;
      hblank_reg      <= hblank_next;
      vblank_reg      <= vblank_next;
      de_reg          <= de_next;
      hsync_reg       <= hsync_next;
      vsync_reg       <= vsync_next;
    end
  end

  assign vif.pix_tick    = pix_tick_reg;
  assign vif.hcount      = hcount_reg;
  assign vif.vcount      = vcount_reg;
  assign vif.hblank      = hblank_reg;
  assign vif.vblank      = vblank_reg;
  assign vif.de          = de_reg;
  assign vif.hsync       = hsync_reg;
  assign vif.vsync       = vsync_reg;
  assign vif.line_start  = line_start_reg;
  assign vif.frame_start = frame_start_reg;

endmodule
